// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, iteration count,
// MIPS DIV/DIVU funct codes and a conditional two's-complement helper.
package div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIVZERO = 2'b01,
    ST_RUN     = 2'b10,
    ST_DONE    = 2'b11
  } div_state_e;

  localparam int unsigned DIV_ITERS = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU): 32 shift-subtract steps, sign fix-up
// on completion, result held while start stays high.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_div
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] pr_q, pr_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sdiv_q, sdiv_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [63:0] res_q, res_d;

  logic [64:0] shifted;
  logic [32:0] trial;
  logic [64:0] step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // One restoring step: shift left, try subtracting the divisor from the upper half.
  always_comb begin
    shifted = {pr_q[63:0], 1'b0};
    trial   = shifted[64:32] - {1'b0, dvs_q};
    step    = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
    q_fix   = neg_if(sdiv_q & (s1_q ^ s2_q), step[31:0]);
    r_fix   = neg_if(sdiv_q & s1_q, step[63:32]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    sdiv_d  = sdiv_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    res_d   = res_q;

    if (annul) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pr_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (opdata2 == '0) begin
              state_d = ST_DIVZERO;
            end else begin
              state_d = ST_RUN;
              cnt_d   = '0;
              sdiv_d  = signed_div;
              s1_d    = opdata1[31];
              s2_d    = opdata2[31];
              dvs_d   = neg_if(signed_div & opdata2[31], opdata2);
              pr_d    = {33'b0, neg_if(signed_div & opdata1[31], opdata1)};
            end
          end
        end
        ST_DIVZERO: begin
          pr_d    = '0;
          res_d   = '0;
          state_d = ST_DONE;
        end
        ST_RUN: begin
          pr_d = step;
          if (cnt_q == 6'(DIV_ITERS - 1)) begin
            state_d = ST_DONE;
            res_d   = {r_fix, q_fix};
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_DONE: begin
          if (!start) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      sdiv_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      sdiv_q  <= sdiv_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      res_q   <= res_d;
    end
  end

  assign ready     = (state_q == ST_DONE);
  assign result    = ready ? res_q : '0;
  assign stall_div = start & ~ready;

endmodule
